// File: rtl/ysyx_24090018_imem_resp_pkg.sv
// Shared constants and types for the fetch-path instruction memory.
// Holds the reset base PC, the reset level and the responder state encoding.
package ysyx_24090018_imem_resp_pkg;

  localparam logic [31:0] PC_BASE    = 32'h8000_0000;
  localparam logic        RST_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/ysyx_24090018_imem_resp_if.sv
// Fetch request/response bundle between the fetch stage and the imem.
// master = fetch stage, slave = memory responder.
interface ysyx_24090018_imem_resp_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic                  rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/ysyx_24090018_imem_resp_array.sv
// DEPTH x 32 instruction storage: synchronous write, combinational read.
// Contents are deliberately not reset so loaded images survive a core reset.
module ysyx_24090018_imem_resp_array #(
  parameter int DEPTH = 1024,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [IW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Backdoor image load port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_24090018_imem_resp.sv
// Fetch-target memory responder with a fixed, parameterised latency.
// Reads are latched at acceptance; bad fetches return err with zero data.
module ysyx_24090018_imem_resp
  import ysyx_24090018_imem_resp_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = PC_BASE,
  parameter int                    LATENCY    = 1,
  localparam int                   IW         = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  ysyx_24090018_imem_resp_if.slave bus,
  input  logic                prog_we,
  input  logic [IW-1:0]       prog_addr,
  input  logic [31:0]         prog_data,
  output logic [31:0]         acc_cnt
);

  localparam logic [ADDR_WIDTH:0] LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] HI =
    LO + (ADDR_WIDTH+1)'(4 * DEPTH);
  localparam logic [3:0] LAT_LOAD =
    (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  lat_q, lat_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [31:0] acc_q, acc_d;

  logic [ADDR_WIDTH:0] a_ext;
  logic [IW-1:0]       idx;
  logic [31:0]         rdata;
  logic                bad;

  assign a_ext = {1'b0, bus.req_addr};
  assign idx   = IW'((bus.req_addr - BASE_ADDR) >> 2);
  assign bad   = (bus.req_addr[1:0] != 2'b00)
              || (a_ext < LO) || (a_ext >= HI);

  ysyx_24090018_imem_resp_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (prog_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(idx),
    .rdata(rdata)
  );

  // State, latency counter, latched response and access counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q <= IDLE;
      lat_q   <= 4'd0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
      acc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
    end
  end

  // Accept in IDLE, count down in WAIT, hold in RESP until taken.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    data_d  = data_q;
    err_d   = err_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          acc_d  = acc_q + 32'd1;
          err_d  = bad;
          data_d = bad ? 32'd0 : rdata;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            lat_d   = LAT_LOAD;
          end
        end
      end
      WAIT: begin
        if (lat_q == 4'd0) state_d = RESP;
        else lat_d = lat_q - 4'd1;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;
  assign acc_cnt       = acc_q;

endmodule

// File: tb/tb_ysyx_24090018_imem_resp.sv
// Scoreboard bench for the imem responder at latencies 1, 4 and 8.
// Expected words come from a bench-side copy of the programmed image.
module tb_ysyx_24090018_imem_resp;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_we = 1'b0;
  logic [9:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic [31:0] acc1, acc4, acc8;

  int checks = 0;
  int failures = 0;

  exp_t        sb [$];
  logic [31:0] mem_m [1024];

  ysyx_24090018_imem_resp_if if1 ();
  ysyx_24090018_imem_resp_if if4 ();
  ysyx_24090018_imem_resp_if if8 ();

  ysyx_24090018_imem_resp #(.LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .bus(if1),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .acc_cnt(acc1)
  );
  ysyx_24090018_imem_resp #(.LATENCY(4)) u4 (
    .clk(clk), .rst(rst), .bus(if4),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .acc_cnt(acc4)
  );
  ysyx_24090018_imem_resp #(.LATENCY(8)) u8 (
    .clk(clk), .rst(rst), .bus(if8),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .acc_cnt(acc8)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog sim_time=%0t limit=500000", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [31:0] a);
    exp_t r;
    logic [31:0] off;
    off = a - 32'h8000_0000;
    r.e = (a[1:0] != 2'b00) || (a < 32'h8000_0000)
       || (a >= 32'h8000_1000);
    r.d = r.e ? 32'd0 : mem_m[off[11:2]];
    return r;
  endfunction

  task automatic prog(input logic [9:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    mem_m[a] = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic fetch1(input logic [31:0] a);
    exp_t e;
    int n;
    sb.push_back(model(a));
    if1.req_valid = 1'b1; if1.req_addr = a;
    n = 0;
    while (!if1.req_ready && n < 20) begin tick(); n++; end
    tick();
    if1.req_valid = 1'b0;
    checks++;
    if (if1.rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL lat1_valid addr=%h got=%b exp=1", a, if1.rsp_valid);
    end
    n = 0;
    while (!if1.rsp_valid && n < 40) begin tick(); n++; end
    e = sb.pop_front();
    checks++;
    if (if1.rsp_data !== e.d || if1.rsp_err !== e.e) begin
      failures++;
      $display("FAIL fetch1 addr=%h got=%h/%b exp=%h/%b",
               a, if1.rsp_data, if1.rsp_err, e.d, e.e);
    end
    tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if (if1.req_ready !== 1'b1 || if1.rsp_valid !== 1'b0 ||
        if1.rsp_data !== 32'd0 || if1.rsp_err !== 1'b0 ||
        acc1 !== 32'd0) begin
      failures++;
      $display("FAIL reset rdy=%b vld=%b data=%h err=%b acc=%h exp=1/0/0/0/0",
               if1.req_ready, if1.rsp_valid, if1.rsp_data,
               if1.rsp_err, acc1);
    end
    checks++;
    if (if4.req_ready !== 1'b1 || acc8 !== 32'd0) begin
      failures++;
      $display("FAIL reset_other rdy4=%b acc8=%h exp=1/0",
               if4.req_ready, acc8);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    prog(10'd0, 32'h0000_0013);
    prog(10'd1, 32'h0010_0093);
    fetch1(32'h8000_0000);
    checks++;
    if (acc1 !== 32'd1) begin
      failures++;
      $display("FAIL basic_acc got=%h exp=1", acc1);
    end
  endtask

  task automatic test_latency();
    exp_t e;
    logic v;
    sb.push_back(model(32'h8000_0004));
    if4.req_valid = 1'b1; if4.req_addr = 32'h8000_0004;
    for (int k = 0; k < 4; k++) begin
      tick();
      v = (k == 3);
      checks++;
      if (if4.req_ready !== 1'b0 || if4.rsp_valid !== v) begin
        failures++;
        $display("FAIL lat4 k=%0d rdy=%b vld=%b exp=0/%b",
                 k, if4.req_ready, if4.rsp_valid, v);
      end
    end
    if4.req_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (if4.rsp_data !== e.d || if4.rsp_err !== e.e) begin
      failures++;
      $display("FAIL lat4_data got=%h/%b exp=%h/%b",
               if4.rsp_data, if4.rsp_err, e.d, e.e);
    end
    tick();
    checks++;
    if (acc4 !== 32'd1 || if4.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat4_done acc=%h vld=%b exp=1/0",
               acc4, if4.rsp_valid);
    end
  endtask

  task automatic test_errors();
    logic [31:0] a0;
    a0 = acc1;
    fetch1(32'h8000_0002);
    fetch1(32'h7FFF_FFFC);
    fetch1(32'h8000_1000);
    fetch1(32'h8000_0FFC);
    checks++;
    if (acc1 !== a0 + 32'd4) begin
      failures++;
      $display("FAIL err_acc got=%h exp=%h", acc1, a0 + 32'd4);
    end
  endtask

  task automatic test_hold();
    exp_t e;
    if1.rsp_ready = 1'b0;
    sb.push_back(model(32'h8000_0004));
    if1.req_valid = 1'b1; if1.req_addr = 32'h8000_0004;
    tick();
    if1.req_valid = 1'b0;
    e = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        prog_we = 1'b1; prog_addr = 10'd1;
        prog_data = 32'hDEAD_BEEF;
        mem_m[1] = 32'hDEAD_BEEF;
      end
      checks++;
      if (if1.rsp_valid !== 1'b1 || if1.rsp_data !== e.d) begin
        failures++;
        $display("FAIL hold i=%0d vld=%b data=%h exp=1/%h",
                 i, if1.rsp_valid, if1.rsp_data, e.d);
      end
      tick();
      prog_we = 1'b0;
    end
    if1.rsp_ready = 1'b1;
    tick();
    checks++;
    if (if1.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_release vld=%b exp=0", if1.rsp_valid);
    end
    fetch1(32'h8000_0004);
  endtask

  task automatic test_same_cycle();
    exp_t e;
    prog(10'd2, 32'h1111_1111);
    sb.push_back(model(32'h8000_0008));
    if1.req_valid = 1'b1; if1.req_addr = 32'h8000_0008;
    prog_we = 1'b1; prog_addr = 10'd2; prog_data = 32'h2222_2222;
    tick();
    prog_we = 1'b0; if1.req_valid = 1'b0;
    mem_m[2] = 32'h2222_2222;
    e = sb.pop_front();
    checks++;
    if (if1.rsp_valid !== 1'b1 || if1.rsp_data !== e.d) begin
      failures++;
      $display("FAIL same_cycle vld=%b data=%h exp=1/%h",
               if1.rsp_valid, if1.rsp_data, e.d);
    end
    tick();
    fetch1(32'h8000_0008);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] a0;
    logic v;
    a0 = acc1;
    sb.push_back(model(32'h8000_0000));
    sb.push_back(model(32'h8000_0000));
    if1.req_valid = 1'b1; if1.req_addr = 32'h8000_0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) if1.req_valid = 1'b0;
      v = (k % 2 == 0);
      checks++;
      if (if1.rsp_valid !== v) begin
        failures++;
        $display("FAIL b2b_valid k=%0d got=%b exp=%b",
                 k, if1.rsp_valid, v);
      end
      if (if1.rsp_valid === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (if1.rsp_data !== e.d) begin
          failures++;
          $display("FAIL b2b_data k=%0d got=%h exp=%h",
                   k, if1.rsp_data, e.d);
        end
      end
    end
    checks++;
    if (acc1 !== a0 + 32'd2 || sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_acc got=%h exp=%h left=%0d",
               acc1, a0 + 32'd2, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int n;
    int seen;
    if8.req_valid = 1'b1; if8.req_addr = 32'h8000_0000;
    tick();
    if8.req_valid = 1'b0;
    tick(); tick();
    checks++;
    if (if8.req_ready !== 1'b0 || if8.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_wait rdy=%b vld=%b exp=0/0",
               if8.req_ready, if8.rsp_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (if8.req_ready !== 1'b1 || if8.rsp_valid !== 1'b0 ||
        if8.rsp_data !== 32'd0 || if8.rsp_err !== 1'b0 ||
        acc8 !== 32'd0) begin
      failures++;
      $display("FAIL async_rst rdy=%b vld=%b data=%h acc=%h exp=1/0/0/0",
               if8.req_ready, if8.rsp_valid, if8.rsp_data, acc8);
    end
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (if8.rsp_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL ghost_rsp got=%0d exp=0", seen);
    end
    sb.push_back(model(32'h8000_0004));
    if8.req_valid = 1'b1; if8.req_addr = 32'h8000_0004;
    tick();
    if8.req_valid = 1'b0;
    n = 0;
    while (!if8.rsp_valid && n < 20) begin tick(); n++; end
    e = sb.pop_front();
    checks++;
    if (n != 7 || if8.rsp_data !== e.d || if8.rsp_err !== e.e) begin
      failures++;
      $display("FAIL lat8 edges=%0d data=%h exp=7/%h",
               n, if8.rsp_data, e.d);
    end
    tick();
  endtask

  task automatic test_wrap();
    force u1.acc_q = 32'hFFFF_FFFF;
    tick();
    release u1.acc_q;
    tick();
    checks++;
    if (acc1 !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL wrap_pre got=%h exp=ffffffff", acc1);
    end
    fetch1(32'h8000_0000);
    checks++;
    if (acc1 !== 32'd0) begin
      failures++;
      $display("FAIL wrap got=%h exp=0", acc1);
    end
  endtask

  initial begin
    if1.req_valid = 1'b0; if1.req_addr = '0; if1.rsp_ready = 1'b1;
    if4.req_valid = 1'b0; if4.req_addr = '0; if4.rsp_ready = 1'b1;
    if8.req_valid = 1'b0; if8.req_addr = '0; if8.rsp_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mem_m[i] = 32'd0;
    test_reset();
    test_basic();
    test_latency();
    test_errors();
    test_hold();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_24090018_imem_resp.md
# ysyx_24090018_imem_resp

Instruction-memory responder for the fetch path: it answers the address produced by the PC register with a 32-bit instruction word. It is the target end of the fetch interface. It accepts one fetch request at a time over a valid/ready handshake and returns data after a fixed, parameterised latency, so the core can be exercised against a non-ideal memory. It also flags misaligned or out-of-range fetches and has a backdoor program port for loading images.

## Interface
- ADDR_WIDTH, 32, fetch address width
- DEPTH, 1024, number of 32-bit words stored
- BASE_ADDR, `ysyx_24090018_PC_Base (32'h8000_0000), byte address of word 0
- LATENCY, 1, cycles from request acceptance to rsp_valid rising; legal range 1..15

- clk  input  1  single clock, all logic on posedge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  fetch request present
- req_ready  output  1  responder can accept a request
- req_addr  input  ADDR_WIDTH  byte address of the fetch (the PC)
- rsp_valid  output  1  response present
- rsp_ready  input  1  fetch stage takes the response
- rsp_data  output  32  instruction word; 0 when rsp_err
- rsp_err  output  1  misaligned or out-of-range fetch
- prog_we  input  1  backdoor write enable
- prog_addr  input  $clog2(DEPTH)  word index for the backdoor write
- prog_data  input  32  backdoor write data
- acc_cnt  output  32  count of accepted requests; wraps at 2^32

## Operation
- The block has three states: IDLE, WAIT and RESP.
- IDLE
  - req_ready=1, rsp_valid=0.
  - On req_valid&&req_ready the request is accepted.
  - The array is read and the result latched into the data/err registers in that same cycle.
  - acc_cnt increments.
  - Next state is RESP if LATENCY==1, otherwise WAIT with lat_cnt loaded to LATENCY-2.
- WAIT
  - req_ready=0, rsp_valid=0.
  - lat_cnt decrements each cycle. When lat_cnt==0, next state is RESP.
- RESP
  - req_ready=0, rsp_valid=1.
  - rsp_data and rsp_err hold stable until rsp_valid&&rsp_ready.
  - On that handshake the next state is IDLE. rsp_ready=0 holds RESP indefinitely.
- Error check, evaluated at acceptance:
  - rsp_err=1 if req_addr[1:0]!=0.
  - rsp_err=1 if req_addr<BASE_ADDR or req_addr>=BASE_ADDR+4*DEPTH.
  - When rsp_err=1, rsp_data=0.
- Word index = (req_addr-BASE_ADDR)>>2, truncated to $clog2(DEPTH) bits. It is used only when the address is in range.
- Backdoor port
  - When prog_we=1, mem[prog_addr] is written at posedge in any state.
  - Because the read is latched at acceptance, a write during WAIT/RESP does not change the pending response.
  - On a write and an accepted read of the same word in the same cycle, the read returns the old word.
- The block has no outstanding-request queue; req_valid outside IDLE is ignored (not accepted).

## Timing
- Reset (async assert) gives:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, lat_cnt=0, acc_cnt=0.
  - Memory contents are not reset.
- Reset asserted mid-transaction drops the pending response; no response appears after reset release.
- Acceptance at posedge T gives rsp_valid=1 from posedge T+LATENCY.
- With rsp_ready held at 1, the next request can be accepted at T+LATENCY+1. Peak throughput is one fetch per LATENCY+1 cycles.
- acc_cnt updates at the acceptance edge and wraps 32'hFFFF_FFFF to 0.
- All outputs are registered or derived from state only; there is no combinational path from inputs to outputs.

## Structure
- The shared defines file holds ysyx_24090018_PC_Base, ysyx_24090018_RstEnable and the state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
- One natural sub-module is ysyx_24090018_imem_array: a DEPTH×32 synchronous-write array with a combinational read. It keeps the storage separate from the handshake FSM.

## Test plan
- Reset, then prog-load mem[0]=32'h0000_0013 and mem[1]=32'h0010_0093. Request 32'h8000_0000 with LATENCY=1 and rsp_ready=1.
  - Response: rsp_valid at T+1 with rsp_data=32'h0000_0013, rsp_err=0, acc_cnt=1.
- LATENCY=4, request 32'h8000_0004.
  - req_ready=0 for T+1..T+4; rsp_valid rises exactly at T+4 with rsp_data=32'h0010_0093.
- Request 32'h8000_0002, then 32'h7FFF_FFFC, then 32'h8000_1000 (DEPTH=1024).
  - Each response: rsp_err=1, rsp_data=0. acc_cnt increments by 3.
- Hold rsp_ready=0 for 10 cycles in RESP while prog_we rewrites the same word to 32'hDEAD_BEEF.
  - rsp_valid and rsp_data hold the old word until rsp_ready=1.
  - A following read of that word returns 32'hDEAD_BEEF.
- Assert rst during WAIT with LATENCY=8.
  - Outputs immediately return to their reset values and no rsp_valid follows. A new request after reset release completes normally.
- Force acc_cnt to 32'hFFFF_FFFF and accept one request.
  - acc_cnt reads 0.
